// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared constants for the SPI frame serializer.
//   State codes are plain localparam constants so older tools and the
//   downstream FSM bench can share the encoding without enum casts.
package spi_frame_pkg;

  // Serializer states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MARK  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // Fixed line levels of the two framing phases of every bit triplet
  localparam logic MARK_BIT  = 1'b1;
  localparam logic TRAIL_BIT = 1'b0;

  // Cycles per transmitted bit (MARK, DATA, TRAIL)
  localparam int BITS_PER_TRIPLET = 3;

  // Number of spi_en cycles in one frame of a given triplet count
  function automatic int frame_cycles(input int triplets);
    return BITS_PER_TRIPLET * triplets;
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: parallel-to-serial SPI frame generator, MSB first, each bit
//   sent as MARK(1) / DATA(bit) / TRAIL(0) with spi_en high for the frame.
//   Latency: accept at an edge, first MARK on the outputs the next cycle.
//   Backpressure: tx_ready only in IDLE; word is latched, input ignored while busy.
// Ports: clock, reset (sync, active-high), tx_data/tx_valid/tx_ready (input
//   handshake), spi_data/spi_en (serial frame), busy, frame_done (last TRAIL).
// Build option: define SPI_FRAME_PARITY_EN to append an even-parity triplet.
module spi_frame_tx
  import spi_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_data,
  output logic              spi_en,
  output logic              busy,
  output logic              frame_done
);

`ifdef SPI_FRAME_PARITY_EN
  localparam int NTRIP = DATA_W + 1;
`else
  localparam int NTRIP = DATA_W;
`endif
  localparam int                CNT_W     = $clog2(NTRIP + 1);
  localparam logic [CNT_W-1:0]  LAST_TRIP = CNT_W'(NTRIP - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  logic [2:0]        state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [7:0]        gap_cnt, gap_nx;
  logic              accept;
  logic              data_bit;

  assign accept = tx_valid & tx_ready;

`ifdef SPI_FRAME_PARITY_EN
  logic par, par_nx;
  // Parity is captured with the word so it survives the shifting
  assign par_nx   = accept ? ^tx_data : par;
  // Triplet index DATA_W is the appended parity triplet
  assign data_bit = (cnt == CNT_W'(DATA_W)) ? par : shreg[DATA_W-1];
  always_ff @(posedge clock) begin
    if (reset) par <= 1'b0;
    else       par <= par_nx;
  end
`else
  assign data_bit = shreg[DATA_W-1];
`endif

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    gap_nx   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_MARK;
          shreg_nx = tx_data;
          cnt_nx   = '0;
        end
      end
      S_MARK:  state_nx = S_DATA;
      S_DATA: begin
        state_nx = S_TRAIL;
        shreg_nx = {shreg[DATA_W-2:0], 1'b0};
      end
      S_TRAIL: begin
        if (cnt == LAST_TRIP) begin
          cnt_nx   = '0;
          gap_nx   = '0;
          state_nx = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_nx   = cnt + 1'b1;
          state_nx = S_MARK;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
        else                     gap_nx   = gap_cnt + 8'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are plain flops and
  // line up cycle-exactly with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      tx_ready   <= 1'b0;
      spi_data   <= 1'b0;
      spi_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      cnt        <= cnt_nx;
      gap_cnt    <= gap_nx;
      tx_ready   <= (state_nx == S_IDLE);
      spi_en     <= (state_nx == S_MARK) || (state_nx == S_DATA) || (state_nx == S_TRAIL);
      busy       <= (state_nx != S_IDLE);
      frame_done <= (state_nx == S_TRAIL) && (cnt_nx == LAST_TRIP);
      if (state_nx == S_MARK)      spi_data <= MARK_BIT;
      else if (state_nx == S_DATA) spi_data <= data_bit;
      else                         spi_data <= TRAIL_BIT;
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: directed + random bench for spi_frame_tx.
//   Two instances: gap 0 (index 0) and gap 4 (index 1); expected line
//   values come from a per-word frame model built from the bit rules.
module tb_spi_frame_tx;
  import spi_frame_pkg::*;

`ifdef SPI_FRAME_PARITY_EN
  localparam int NT = 9;
`else
  localparam int NT = 8;
`endif
  localparam int FL = BITS_PER_TRIPLET * NT;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset [2];
  logic [7:0] dat   [2];
  logic       vld   [2];
  logic       rdy   [2];
  logic       sd    [2];
  logic       en    [2];
  logic       bsy   [2];
  logic       fd    [2];

  int total = 0;
  int bad   = 0;

  spi_frame_tx #(.DATA_W(8), .GAP_CYCLES(0)) u0 (
    .clock(clock), .reset(reset[0]), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .spi_data(sd[0]), .spi_en(en[0]), .busy(bsy[0]),
    .frame_done(fd[0]));

  spi_frame_tx #(.DATA_W(8), .GAP_CYCLES(4)) u1 (
    .clock(clock), .reset(reset[1]), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .spi_data(sd[1]), .spi_en(en[1]), .busy(bsy[1]),
    .frame_done(fd[1]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line value for frame cycle i of word w: triplet i/3, phase i%3
  function automatic logic expbit(input logic [7:0] w, input int i);
    int t;
    int ph;
    t  = i / 3;
    ph = i % 3;
    if (ph == 0) return 1'b1;
    if (ph == 2) return 1'b0;
    if (t < 8)   return w[7 - t];
    return ^w;
  endfunction

  // Called at the negedge of the first MARK cycle. Checks the frame, the
  // gap and the following idle cycle; returns at that idle negedge.
  // With stop_at >= 0 it returns at the negedge of frame cycle stop_at.
  task automatic expect_frame(input int d, input logic [7:0] w, input int gap,
                              input bit scramble, input int stop_at);
    for (int i = 0; i < FL; i++) begin
      if (stop_at >= 0 && i == stop_at) return;
      chk($sformatf("frame d%0d w=%h cyc%0d {en,data,done,rdy,busy}", d, w, i),
          8'({en[d], sd[d], fd[d], rdy[d], bsy[d]}),
          8'({1'b1, expbit(w, i), (i == FL - 1), 1'b0, 1'b1}));
      if (scramble) dat[d] = 8'($urandom);
      @(negedge clock);
    end
    for (int g = 0; g < gap; g++) begin
      chk($sformatf("gap d%0d g%0d {en,data,rdy,busy,done}", d, g),
          8'({en[d], sd[d], rdy[d], bsy[d], fd[d]}), 8'b00010);
      @(negedge clock);
    end
    chk($sformatf("idle d%0d {en,data,rdy,busy,done}", d),
        8'({en[d], sd[d], rdy[d], bsy[d], fd[d]}), 8'b00100);
  endtask

  task automatic send(input int d, input logic [7:0] w, input int gap);
    int n;
    n = 0;
    while (rdy[d] !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("ready_wait d%0d", d), 8'(rdy[d]), 8'd1);
    dat[d] = w;
    vld[d] = 1'b1;
    @(negedge clock);
    vld[d] = 1'b0;
    dat[d] = 8'($urandom);
    expect_frame(d, w, gap, 1'b0, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      vld[k]   = 1'b0;
      dat[k]   = 8'h00;
    end

    // 1: reset held 5 cycles, then ready on the first cycle after release
    repeat (5) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++)
        chk($sformatf("in_reset d%0d {en,data,rdy,busy,done}", k),
            8'({en[k], sd[k], rdy[k], bsy[k], fd[k]}), 8'b00000);
    end
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 2; k++)
      chk($sformatf("after_reset d%0d {en,data,rdy,busy,done}", k),
          8'({en[k], sd[k], rdy[k], bsy[k], fd[k]}), 8'b00100);

    // 2: single frame of A5
    send(0, 8'hA5, 0);

    // 3: tx_valid held, 3C then FF, input data churning during frame 1
    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    @(negedge clock);
    expect_frame(0, 8'h3C, 0, 1'b1, -1);
    dat[0] = 8'hFF;
    @(negedge clock);
    vld[0] = 1'b0;
    expect_frame(0, 8'hFF, 0, 1'b0, -1);

    // 4: gap of 4 cycles after an all-zero frame
    send(1, 8'h00, 4);

    // 5: reset at frame cycle 10 of 81, valid held through reset
    @(negedge clock);
    dat[0] = 8'h81;
    vld[0] = 1'b1;
    @(negedge clock);
    vld[0] = 1'b0;
    expect_frame(0, 8'h81, 0, 1'b0, 9);
    reset[0] = 1'b1;
    vld[0]   = 1'b1;
    dat[0]   = 8'h55;
    repeat (3) begin
      @(negedge clock);
      chk("mid_reset {en,data,rdy,busy,done}",
          8'({en[0], sd[0], rdy[0], bsy[0], fd[0]}), 8'b00000);
    end
    reset[0] = 1'b0;
    vld[0]   = 1'b0;
    @(negedge clock);
    chk("post_abort {en,data,rdy,busy,done}",
        8'({en[0], sd[0], rdy[0], bsy[0], fd[0]}), 8'b00100);
    send(0, 8'h01, 0);

    // 6: parity-sensitive words
    send(0, 8'h07, 0);
    send(0, 8'h03, 0);

    // Random words with random idle spacing on both instances
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send(0, 8'($urandom), 0);
    end
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      send(1, 8'($urandom), 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
